// File: rtl/bfloat_pkg.sv
// Shared bfloat16 field layout, constants and the accumulator FSM state type.
package bfloat_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 7;
  localparam int MANT_W   = 7;

  localparam logic [15:0] BF_ZERO    = 16'h0000;
  localparam logic [14:0] BF_INF_MAG = 15'h7F80;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // Both +0 and -0 count as zero; the sign bit is ignored.
  function automatic logic is_zero(input logic [15:0] v);
    return (v[EXP_MSB:0] == 15'h0000);
  endfunction

endpackage

// File: rtl/bfloat_adder.sv
// Combinational bfloat16 magnitude adder. Both operands carry a hidden 1, the
// smaller one is aligned by truncating right shift, and the result takes the
// sign of a. The exponent is allowed to wrap so the caller can detect overflow.
module bfloat_adder
  import bfloat_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c
);

  logic [7:0]        ea, eb, e_big, diff, e_res;
  logic [7:0]        m_big, m_small, m_shift;
  logic [8:0]        sum;
  logic [MANT_W-1:0] mant;
  logic              unused_b_sign;

  // Only magnitudes are added, so b's sign never matters.
  assign unused_b_sign = b[SIGN_BIT];

  // Align, add and renormalise by at most one position.
  always_comb begin
    ea = a[EXP_MSB:EXP_LSB];
    eb = b[EXP_MSB:EXP_LSB];
    if (ea >= eb) begin
      e_big   = ea;
      diff    = ea - eb;
      m_big   = {1'b1, a[MANT_W-1:0]};
      m_small = {1'b1, b[MANT_W-1:0]};
    end else begin
      e_big   = eb;
      diff    = eb - ea;
      m_big   = {1'b1, b[MANT_W-1:0]};
      m_small = {1'b1, a[MANT_W-1:0]};
    end
    m_shift = m_small >> diff;
    sum     = {1'b0, m_big} + {1'b0, m_shift};
    if (sum[8]) begin
      e_res = e_big + 8'd1;
      mant  = sum[7:1];
    end else begin
      e_res = e_big;
      mant  = sum[6:0];
    end
    c = {a[SIGN_BIT], e_res, mant};
  end

endmodule

// File: rtl/bfloat_frame_accum.sv
// Streaming bfloat16 frame accumulator: folds one sample per cycle into a
// magnitude sum, skips zeros, saturates on exponent overflow and hands the
// frame result out on a valid/ready stream.
module bfloat_frame_accum
  import bfloat_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_t           state, state_nxt;
  logic [15:0]      acc, acc_nxt, sum;
  logic             empty, empty_nxt, ovf, ovf_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [7:0]       exp_max, res_exp;
  logic             add_ovf, accept, frame_end, out_fire;

  bfloat_adder u_add (
    .a(acc),
    .b(in_data),
    .c(sum)
  );

  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign cnt_inc   = cnt + CNT_W'(1);
  // A last flag on the FRAME_LEN-th beat is still a single frame end.
  assign frame_end = accept & ((cnt_inc == CNT_W'(FRAME_LEN)) | in_last);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC: if (frame_end) state_nxt = S_OUT;
      S_OUT: if (out_fire)  state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // Handshake outputs; in_ready is held low while reset is applied.
  always_comb begin
    in_ready  = (state == S_ACC) & ~rst;
    out_valid = (state == S_OUT);
  end

  // Fold the current sample into the running sum, detecting exponent wrap.
  always_comb begin
    acc_nxt   = acc;
    empty_nxt = empty;
    ovf_nxt   = ovf;
    exp_max   = (acc[EXP_MSB:EXP_LSB] >= in_data[EXP_MSB:EXP_LSB]) ?
                acc[EXP_MSB:EXP_LSB] : in_data[EXP_MSB:EXP_LSB];
    res_exp   = sum[EXP_MSB:EXP_LSB];
    add_ovf   = (res_exp == 8'hFF) | (res_exp < exp_max);
    if (!is_zero(in_data)) begin
      if (empty) begin
        acc_nxt   = in_data;
        empty_nxt = 1'b0;
      end else if (!ovf) begin
        if (add_ovf) begin
          ovf_nxt = 1'b1;
          acc_nxt = {acc[SIGN_BIT], BF_INF_MAG};
        end else begin
          acc_nxt = sum;
        end
      end
    end
  end

  // Accumulator, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= BF_ZERO;
      empty     <= 1'b1;
      ovf       <= 1'b0;
      cnt       <= '0;
      out_data  <= BF_ZERO;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_nxt;
      empty <= empty_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_inc;
      if (frame_end) begin
        out_data  <= empty_nxt ? BF_ZERO : acc_nxt;
        out_count <= cnt_inc;
        out_ovf   <= ovf_nxt;
      end
    end else if (out_fire) begin
      acc   <= BF_ZERO;
      empty <= 1'b1;
      ovf   <= 1'b0;
      cnt   <= '0;
    end
  end

endmodule

// File: doc/bfloat_frame_accum.md
# bfloat_frame_accum

Streaming bfloat16 frame accumulator placed directly downstream of the combinational `bfloat_adder`, which it instantiates once as its add datapath. Samples arrive on a valid/ready stream and are folded into a running sum, one per cycle. At the end of a frame of FRAME_LEN samples, or on an early `in_last`, the registered sum is presented on an output valid/ready stream. The block adds zero handling, magnitude-only accumulation and exponent-overflow saturation, none of which the bare adder provides.

## Interface
- FRAME_LEN, 8: samples per frame (≥2)
- CNT_W, $clog2(FRAME_LEN+1): width of the sample counter and `out_count`
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- in_data  in  16  bfloat16 sample {sign, exp[7:0], mant[6:0]}
- in_last  in  1  final sample of frame (qualified by in_valid & in_ready)
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- out_data  out  16  bfloat16 frame sum
- out_count  out  CNT_W  samples accepted in frame, including zeros
- out_ovf  out  1  sum overflowed; out_data is saturated

## Operation
- FSM states: S_ACC (accepting samples) and S_OUT (holding result). Reset state is S_ACC.
- Registers: acc[15:0], empty, ovf, cnt.
- `in_ready` = (state == S_ACC); forced to 0 while rst is high.
- A sample is zero when in_data[14:0] == 0. A zero sample increments cnt only; acc is unchanged.
- The adder treats every operand as having a hidden 1, so it is never fed a zero.
- Non-zero sample while empty=1: load acc = in_data, then clear empty.
- Non-zero sample while empty=0 and ovf=0: acc <= adder(a=acc, b=in_data).
  - The adder adds magnitudes only, so acc keeps the sign of the first non-zero sample. This is a magnitude sum by definition.
- Overflow is detected when res_exp == 8'hFF, or when res_exp < max(acc_exp, in_exp) (exponent wrap). On overflow:
  - set ovf;
  - acc <= {acc[15], 8'hFF, 7'h00}.
  - Later samples in the same frame are counted but not added.
- Frame end: an accepted beat with cnt+1 == FRAME_LEN or in_last=1.
  - On that edge: state <= S_OUT; out_data, out_count and out_ovf are loaded from the updated values.
  - If every sample was zero, out_data = 16'h0000.
- S_OUT: out_valid=1. When out_valid & out_ready, state <= S_ACC and acc, empty (=1), ovf and cnt are cleared on the same edge.
- Output registers stay stable while out_valid=1 and out_ready=0.
- in_last on a beat where cnt+1 == FRAME_LEN counts as a single frame end, not two.

## Timing
- Reset values: in_ready 0 while rst is asserted; out_valid 0, out_data 16'h0000, out_count 0, out_ovf 0; internal acc 0, empty 1, ovf 0, cnt 0.
- in_ready goes to 1 on the first cycle after rst deasserts.
- Throughput is one sample per cycle in S_ACC.
- Latency: out_valid rises on the first cycle after the frame-end beat is accepted.
- in_ready is 0 for every cycle spent in S_OUT.
- Minimum period per frame: FRAME_LEN + 1 cycles when out_ready is held high.
- rst asserted mid-frame or in S_OUT discards all state immediately and returns every output to its reset value; no partial result is emitted.
- The adder path is combinational from acc and in_data into acc; there is one register stage.

## Structure
- Shared package `bfloat_pkg`:
  - field-slice localparams (SIGN_BIT=15, EXP_MSB=14, EXP_LSB=7, MANT_W=7);
  - BF_ZERO = 16'h0000;
  - BF_INF_MAG = 15'h7F80;
  - is_zero helper function.
- Sub-module: one `bfloat_adder` instance (a=acc, b=in_data, c=sum).
- The FSM, counter and overflow logic live in this module.

## Test plan
- FRAME_LEN=4, inputs 3F80,3F80,3F80,3F80 → out_data 4080, out_count 4, out_ovf 0, out_valid one cycle after the 4th beat.
- 4000, then 4040 with in_last=1 → out_data 40A0, out_count 2; the next frame starts from empty.
- 0000, 8000, 3F80, 0000 → out_data 3F80, out_count 4. All-zero frame → out_data 0000.
- BF80, then 3F80, 3F80, 3F80 → out_data C080 (sign taken from first non-zero sample).
- 7F00 + 7F00, then 3F80 ×2 → out_ovf 1, out_data 7F80, out_count 4.
- Hold out_ready=0 for 3 cycles in S_OUT → out_data stable and in_ready 0 throughout. Assert rst mid-frame after 2 beats → out_valid stays 0, and the next frame sums from empty.
